// File: rtl/factorial_seq_unit.sv
// Sequential n! / n!! calculator: one multiply per clock, saturating on overflow.
// The result registers keep the last completed answer while a new computation runs.
module factorial_seq_unit #(
  parameter int unsigned N_WIDTH      = 5,
  parameter int unsigned RESULT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode,
  input  logic [N_WIDTH-1:0]      n,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic                    overflow,
  output logic [RESULT_WIDTH-1:0] result
);

  localparam int unsigned PROD_WIDTH = RESULT_WIDTH + N_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic [N_WIDTH-1:0]      k_q, k_d;
  logic                    mode_q, mode_d;
  logic                    ovf_q, ovf_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic                    overflow_q, overflow_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [PROD_WIDTH-1:0]   prod_c;
  logic                    prod_ovf_c;
  logic                    k_last_c;
  logic                    accept_c;

  assign prod_c     = PROD_WIDTH'(acc_q) * PROD_WIDTH'(k_q);
  assign prod_ovf_c = |prod_c[PROD_WIDTH-1:RESULT_WIDTH];
  assign k_last_c   = (k_q <= N_WIDTH'(1));
  // DONE accepts a new request exactly like IDLE; abort always wins over start
  assign accept_c   = (state_q != S_CALC) && start && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) state_d = S_CALC;
      end
      S_CALC: begin
        if (abort)         state_d = S_IDLE;
        else if (k_last_c) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    k_d        = k_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    busy_d     = (state_d == S_CALC);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          acc_d   = RESULT_WIDTH'(1);
          k_d     = n;
          mode_d  = mode;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
        end
      end
      S_CALC: begin
        if (!abort) begin
          if (k_last_c) begin
            result_d   = acc_q;
            overflow_d = ovf_q;
            valid_d    = 1'b1;
            done_d     = 1'b1;
          end else begin
            // k > 1 here, so neither step can wrap below zero
            k_d = mode_q ? (k_q - N_WIDTH'(2)) : (k_q - N_WIDTH'(1));
            if (!ovf_q) begin
              if (prod_ovf_c) begin
                ovf_d = 1'b1;
                acc_d = '1;
              end else begin
                acc_d = prod_c[RESULT_WIDTH-1:0];
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= RESULT_WIDTH'(1);
      k_q        <= '0;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      k_q        <= k_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign result   = result_q;

endmodule

// File: tb/tb_factorial_seq_unit.sv
// Scoreboard bench for factorial_seq_unit: a behavioural model predicts each answer,
// its completion edge and busy length; a negedge monitor pops and compares on done.
module tb_factorial_seq_unit;

  localparam int unsigned NW = 5;
  localparam int unsigned RW = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          mode;
  logic [NW-1:0] n;
  logic          busy;
  logic          done;
  logic          valid;
  logic          overflow;
  logic [RW-1:0] result;

  typedef struct {
    logic [63:0] res;
    logic        ov;
    int          due;
    int          busy_len;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   busy_run  = 0;
  logic busy_prev = 1'b0;

  factorial_seq_unit #(.N_WIDTH(NW), .RESULT_WIDTH(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .valid    (valid),
    .overflow (overflow),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: multiply down from n, saturating to all ones once the product leaves RW bits
  task automatic ref_calc(input int nn, input logic md, output logic [63:0] r,
                          output logic ov, output int m);
    r  = 64'd1;
    ov = 1'b0;
    m  = 0;
    for (int k = nn; k > 1; k -= (md ? 2 : 1)) begin
      m++;
      if (!ov) begin
        r = r * 64'(k);
        if (r > 64'hFFFF_FFFF) begin
          ov = 1'b1;
          r  = 64'hFFFF_FFFF;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_run = (busy_prev === 1'b1) ? busy_run + 1 : 1;
    busy_prev = busy;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result",       64'(result),   e.res);
        chk("overflow",     64'(overflow), 64'(e.ov));
        chk("valid",        64'(valid),    64'd1);
        chk("busy_at_done", 64'(busy),     64'd0);
        chk("done_edge",    64'(cyc),      64'(e.due));
        chk("busy_cycles",  64'(busy_run), 64'(e.busy_len));
      end
    end
  end

  // Pulse start for one edge; returns 1ns after the sampling edge E0
  task automatic issue(input int nn, input logic md, input bit push);
    exp_t        e;
    logic [63:0] r;
    logic        ov;
    int          m;
    @(posedge clk);
    #1;
    start = 1'b1;
    n     = NW'(nn);
    mode  = md;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      ref_calc(nn, md, r, ov, m);
      e.res      = r;
      e.ov       = ov;
      e.due      = cyc + m + 1;
      e.busy_len = m + 1;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    n     = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_valid",    64'(valid),    64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_result",   64'(result),   64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(5, 1'b0, 1'b1);
    drain();
    chk("fact5_value", 64'(result), 64'd120);

    issue(0, 1'b0, 1'b1);
    drain();
    chk("fact0_value", 64'(result), 64'd1);
    issue(1, 1'b0, 1'b1);
    drain();
    chk("fact1_value", 64'(result), 64'd1);

    issue(12, 1'b0, 1'b1);
    chk("result_hold_calc", 64'(result), 64'd1);
    chk("valid_clr_calc",   64'(valid),  64'd0);
    chk("busy_calc",        64'(busy),   64'd1);
    drain();
    chk("fact12_value", 64'(result), 64'd479001600);

    issue(13, 1'b0, 1'b1);
    drain();
    chk("fact13_sat", 64'(result),   64'hFFFF_FFFF);
    chk("fact13_ovf", 64'(overflow), 64'd1);

    issue(9, 1'b1, 1'b1);
    drain();
    chk("dfact9_value", 64'(result), 64'd945);
    issue(8, 1'b1, 1'b1);
    drain();
    chk("dfact8_value", 64'(result), 64'd384);
    issue(20, 1'b1, 1'b1);
    drain();
    issue(31, 1'b1, 1'b1);
    drain();

    // second start lands in CALC and must be ignored
    issue(6, 1'b0, 1'b1);
    issue(3, 1'b0, 1'b0);
    drain();
    chk("ignore_start_value", 64'(result), 64'd720);

    // abort during the third CALC cycle
    issue(10, 1'b0, 1'b0);
    chk("abort_valid_clr", 64'(valid), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy_drop", 64'(busy), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("abort_valid",  64'(valid),  64'd0);
    chk("abort_result", 64'(result), 64'd720);

    // abort blocks a same-cycle start in IDLE
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    n     = NW'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_blocks_start", 64'(busy), 64'd0);

    // asynchronous reset in the middle of n=9
    issue(9, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_busy",     64'(busy),     64'd0);
    chk("mid_rst_done",     64'(done),     64'd0);
    chk("mid_rst_valid",    64'(valid),    64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_result",   64'(result),   64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    issue(4, 1'b0, 1'b1);
    drain();
    chk("post_rst_value", 64'(result), 64'd24);
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
